// File: rtl/iawif_mc_if.sv
// -----------------------------------------------------------------------------
// iawif_mc_if
//   Bus bundle between the IAW emulation logic / CPU (master) and the IAW
//   emulation interface block (slave).
//
//   Parameter
//     NCH        number of IAW reset request channels (1..8)
//
//   Signals (direction seen from the slave)
//     SVMOD      in   CPU supervisor-mode indicator
//     SOFTBRK    in   software break in progress, freezes the mask FSM
//     CPUWR      in   CPU write strobe
//     IAWRES     in   per-channel IAW reset request, active high, level
//     IAWMSK     in   per-channel disable, 1 = channel ignored
//     CAUSECLR   in   single-cycle clear of IAWCAUSE
//     SVSTOPIAW  out  SVMOD qualified past the mask window
//     CPUWRIAW   out  CPUWR with the stack-write window removed
//     MASKACT    out  mask window currently active
//     PERISVIB   out  peripheral break request, active low
//     IAWCAUSE   out  sticky record of channels that requested
// -----------------------------------------------------------------------------
interface iawif_mc_if #(
    parameter int NCH = 2
);
    logic           SVMOD;
    logic           SOFTBRK;
    logic           CPUWR;
    logic [NCH-1:0] IAWRES;
    logic [NCH-1:0] IAWMSK;
    logic           CAUSECLR;
    logic           SVSTOPIAW;
    logic           CPUWRIAW;
    logic           MASKACT;
    logic           PERISVIB;
    logic [NCH-1:0] IAWCAUSE;

    modport master (
        output SVMOD, SOFTBRK, CPUWR, IAWRES, IAWMSK, CAUSECLR,
        input  SVSTOPIAW, CPUWRIAW, MASKACT, PERISVIB, IAWCAUSE
    );

    modport slave (
        input  SVMOD, SOFTBRK, CPUWR, IAWRES, IAWMSK, CAUSECLR,
        output SVSTOPIAW, CPUWRIAW, MASKACT, PERISVIB, IAWCAUSE
    );
endinterface

// File: rtl/iawif_mc.sv
// -----------------------------------------------------------------------------
// iawif_mc
//   Multi-channel IAW emulation interface.
//   * Merges NCH illegal-access-watchdog reset requests into one active-low
//     peripheral-break strobe (PERISVIB), stretched by STRETCH cycles after
//     the last active request, and records the firing channels in the sticky
//     IAWCAUSE register.
//   * Generates the SVMOD stack-write mask: CPUWR is suppressed for the first
//     MASK_CYC SVMOD-high cycles (SOFTBRK cycles do not count), so IAW access
//     checks ignore the supervisor stack pushes.
//   With MASK_CYC=1 and STRETCH=0 it matches the old single-channel interface.
//
//   Parameters
//     NCH       number of request channels (1..8), must match the interface
//     MASK_CYC  SVMOD-high cycles during which CPUWR is masked (>=1)
//     STRETCH   extra PERISVIB-low cycles after the last request (0..255)
//
//   Ports
//     FCLKRT    clock, rising edge
//     RESB      asynchronous active-low reset
//     bus       iawif_mc_if slave modport (see interface header)
//
//   Optional build macro
//     IAWIF_SYNC_EN  when defined, IAWRES passes through a per-bit 2-flop
//                    synchroniser before masking (+2 cycles latency to
//                    PERISVIB assertion and IAWCAUSE setting). When undefined
//                    the IAWRES -> PERISVIB path is purely combinational.
// -----------------------------------------------------------------------------
module iawif_mc #(
    parameter int NCH      = 2,
    parameter int MASK_CYC = 1,
    parameter int STRETCH  = 0
) (
    input  logic         FCLKRT,
    input  logic         RESB,
    iawif_mc_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MASK = 2'd1,
        STOP = 2'd2
    } state_e;

    // A 1-cycle window never enters MASK, so the counter is kept 1 bit wide
    // there instead of collapsing to zero width.
    localparam int CNT_W = (MASK_CYC > 1) ? $clog2(MASK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MASK_CYC > 1) ? MASK_CYC - 2 : 0);
    localparam int BRK_W = 8;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
    logic [NCH-1:0]   cause_q, cause_d;
    logic [NCH-1:0]   iawres_eff;
    logic [NCH-1:0]   req;

    // -------------------------------------------------------------------------
    // Request input conditioning
    // -------------------------------------------------------------------------
`ifdef IAWIF_SYNC_EN
    logic [NCH-1:0] sync1_q, sync1_d;
    logic [NCH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = bus.IAWRES;
        sync2_d = sync1_q;
    end

    // NOTE: sequential state is only ever written with non-blocking
    // assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge FCLKRT or negedge RESB) begin
        if (!RESB) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign iawres_eff = sync2_q;
`else
    assign iawres_eff = bus.IAWRES;
`endif

    assign req = iawres_eff & ~bus.IAWMSK;

    // -------------------------------------------------------------------------
    // Mask FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge FCLKRT or negedge RESB) begin
        if (!RESB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Mask FSM: next state. SOFTBRK freezes both state and counter, which is
    // what keeps SOFTBRK cycles out of the window count.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: hold values are assigned first so no path through the case
        // leaves a variable unassigned (which would infer a latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.SOFTBRK) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.SVMOD) begin
                        if (MASK_CYC == 1) begin
                            state_d = STOP;
                        end else begin
                            state_d = MASK;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                MASK: begin
                    if (!bus.SVMOD) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (!bus.SVMOD) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Mask FSM: outputs. Qualifying with the live SVMOD (rather than a
    // registered copy) keeps SVSTOPIAW glitch-free when SOFTBRK and SVMOD
    // change together.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.MASKACT   = bus.SVMOD & (state_q != STOP);
        bus.CPUWRIAW  = bus.CPUWR & ~bus.MASKACT;
        bus.SVSTOPIAW = bus.SVMOD & (state_q == STOP);
    end

    // -------------------------------------------------------------------------
    // Break stretch and sticky cause
    // -------------------------------------------------------------------------
    always_comb begin
        brk_cnt_d = brk_cnt_q;
        if (|req) begin
            // Any request, including one during the stretch, reloads the
            // full stretch length.
            brk_cnt_d = BRK_W'(STRETCH);
        end else if (brk_cnt_q != '0) begin
            brk_cnt_d = brk_cnt_q - BRK_W'(1);
        end

        // Set wins over clear; IAWMSK only gates new sets.
        cause_d = (cause_q & ~{NCH{bus.CAUSECLR}}) | req;
    end

    always_ff @(posedge FCLKRT or negedge RESB) begin
        if (!RESB) begin
            brk_cnt_q <= '0;
            cause_q   <= '0;
        end else begin
            brk_cnt_q <= brk_cnt_d;
            cause_q   <= cause_d;
        end
    end

    // The live request term gives zero-latency assertion; the counter only
    // extends the low phase after the request has gone.
    assign bus.PERISVIB = ~((|req) | (brk_cnt_q != '0));
    assign bus.IAWCAUSE = cause_q;

endmodule

// File: tb/tb_iawif_mc.sv
// -----------------------------------------------------------------------------
// tb_iawif_mc
//   Self-checking bench for iawif_mc. Three instances with different
//   MASK_CYC/STRETCH share one stimulus stream; a behavioural model counts
//   SVMOD-high non-SOFTBRK cycles and cycles since the last request to derive
//   the expected outputs for every instance every cycle.
// -----------------------------------------------------------------------------
module tb_iawif_mc;

    localparam int NCH  = 2;
    localparam int NDUT = 3;
    localparam int NONE = 100000;   // "no request seen yet"

    logic           clk = 1'b0;
    logic           rst_n;
    logic           svmod, softbrk, cpuwr, causeclr;
    logic [NCH-1:0] iawres, iawmsk;

    logic [NDUT-1:0] o_maskact, o_cpuwriaw, o_svstop, o_perisvib;
    logic [NCH-1:0]  o_cause [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        iawif_mc_if #(.NCH(NCH)) bus ();

        assign bus.SVMOD    = svmod;
        assign bus.SOFTBRK  = softbrk;
        assign bus.CPUWR    = cpuwr;
        assign bus.IAWRES   = iawres;
        assign bus.IAWMSK   = iawmsk;
        assign bus.CAUSECLR = causeclr;

        iawif_mc #(
            .NCH      (NCH),
            .MASK_CYC (g == 0 ? 1 : (g == 1 ? 3 : 2)),
            .STRETCH  (g == 0 ? 0 : (g == 1 ? 4 : 2))
        ) u_dut (
            .FCLKRT (clk),
            .RESB   (rst_n),
            .bus    (bus)
        );

        assign o_maskact[g]  = bus.MASKACT;
        assign o_cpuwriaw[g] = bus.CPUWRIAW;
        assign o_svstop[g]   = bus.SVSTOPIAW;
        assign o_perisvib[g] = bus.PERISVIB;
        assign o_cause[g]    = bus.IAWCAUSE;
    end

    // ---------------- reference model ----------------
    int             mc_m [NDUT] = '{1, 3, 2};
    int             st_m [NDUT] = '{0, 4, 2};
    int             seen [NDUT];       // counted SVMOD-high cycles this run
    int             since_req [NDUT];  // cycles since the last request cycle
    logic [NCH-1:0] cause_m [NDUT];
    logic [NCH-1:0] sync1_m, sync2_m;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] req_m();
        logic [NCH-1:0] eff;
`ifdef IAWIF_SYNC_EN
        eff = sync2_m;
`else
        eff = iawres;
`endif
        return eff & ~iawmsk;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NDUT; g++) begin
            seen[g]      = 0;
            since_req[g] = NONE;
            cause_m[g]   = '0;
        end
        sync1_m = '0;
        sync2_m = '0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] r;
        r = req_m();
        for (int g = 0; g < NDUT; g++) begin
            if (!softbrk) begin
                if (!svmod)               seen[g] = 0;
                else if (seen[g] < mc_m[g]) seen[g] = seen[g] + 1;
            end
            if (|r)                    since_req[g] = 1;
            else if (since_req[g] < NONE) since_req[g] = since_req[g] + 1;
            cause_m[g] = (causeclr ? '0 : cause_m[g]) | r;
        end
        sync2_m = sync1_m;
        sync1_m = iawres;
    endtask

    task automatic check_all(input string ctx);
        logic [NCH-1:0] r;
        logic m, exp_peri;
        r = req_m();
        for (int g = 0; g < NDUT; g++) begin
            m = svmod && (seen[g] < mc_m[g]);
            exp_peri = !((|r) || (since_req[g] >= 1 && since_req[g] <= st_m[g]));
            check($sformatf("%s/dut%0d/MASKACT", ctx, g),   32'(o_maskact[g]),  32'(m));
            check($sformatf("%s/dut%0d/CPUWRIAW", ctx, g),  32'(o_cpuwriaw[g]), 32'(cpuwr & !m));
            check($sformatf("%s/dut%0d/SVSTOPIAW", ctx, g), 32'(o_svstop[g]),   32'(svmod && seen[g] >= mc_m[g]));
            check($sformatf("%s/dut%0d/PERISVIB", ctx, g),  32'(o_perisvib[g]), 32'(exp_peri));
            check($sformatf("%s/dut%0d/IAWCAUSE", ctx, g),  32'(o_cause[g]),    32'(cause_m[g]));
        end
    endtask

    // Check mid-cycle, then let the clock edge advance DUT and model together.
    task automatic run(input string ctx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all(ctx);
            @(posedge clk);
            if (rst_n) model_step();
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; svmod = 1'b0; softbrk = 1'b0; cpuwr = 1'b0;
        causeclr = 1'b0; iawres = '0; iawmsk = '0;
        model_reset();

        // Reset state, checked against fixed values.
        #3;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset/dut%0d/MASKACT", g),   32'(o_maskact[g]),  32'd0);
            check($sformatf("reset/dut%0d/SVSTOPIAW", g), 32'(o_svstop[g]),   32'd0);
            check($sformatf("reset/dut%0d/PERISVIB", g),  32'(o_perisvib[g]), 32'd1);
            check($sformatf("reset/dut%0d/IAWCAUSE", g),  32'(o_cause[g]),    32'd0);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        run("idle", 2);

        // Mask window with CPUWR held.
        cpuwr = 1'b1; svmod = 1'b1;  run("window", 6);
        svmod = 1'b0;                run("window_end", 2);

        // Early SVMOD drop then full restart.
        svmod = 1'b1;  run("restart_a", 1);
        svmod = 1'b0;  run("restart_b", 1);
        svmod = 1'b1;  run("restart_c", 5);
        svmod = 1'b0;  run("restart_d", 2);

        // SOFTBRK freeze mid-window.
        svmod = 1'b1;   run("freeze_a", 1);
        softbrk = 1'b1; run("freeze_b", 4);
        softbrk = 1'b0; run("freeze_c", 4);
        svmod = 1'b0;   run("freeze_d", 2);

        // SOFTBRK while SVMOD falls and comes back.
        svmod = 1'b1;                  run("sbfall_a", 2);
        softbrk = 1'b1; svmod = 1'b0;  run("sbfall_b", 2);
        svmod = 1'b1;                  run("sbfall_c", 1);
        softbrk = 1'b0;                run("sbfall_d", 3);
        svmod = 1'b0; cpuwr = 1'b0;    run("sbfall_e", 2);

        // Single-cycle request, stretch, cause and clear.
        iawres = 2'b10;  run("stretch_a", 1);
        iawres = 2'b00;  run("stretch_b", 9);
        causeclr = 1'b1; run("clear_a", 1);
        causeclr = 1'b0; run("clear_b", 3);

        // Clear coinciding with a request: set wins.
        iawres = 2'b10; causeclr = 1'b1; run("setwins_a", 1);
        iawres = 2'b00; causeclr = 1'b0; run("setwins_b", 4);
        causeclr = 1'b1; run("setwins_c", 1);
        causeclr = 1'b0;

        // Retrigger inside the stretch.
        iawres = 2'b01; run("retrig_a", 1);
        iawres = 2'b00; run("retrig_b", 2);
        iawres = 2'b01; run("retrig_c", 1);
        iawres = 2'b00; run("retrig_d", 7);

        // Masked channel never breaks nor records.
        causeclr = 1'b1; run("pre_mask", 1);
        causeclr = 1'b0;
        iawmsk = 2'b01; iawres = 2'b01; run("chmask", 10);
        iawres = 2'b00;                 run("chmask_end", 3);
        iawmsk = 2'b00;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            svmod    = ($urandom_range(0, 3) != 0) ? svmod : ~svmod;
            softbrk  = ($urandom_range(0, 5) == 0);
            cpuwr    = 1'($urandom);
            iawres   = ($urandom_range(0, 6) == 0) ? NCH'($urandom) : '0;
            iawmsk   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            causeclr = ($urandom_range(0, 7) == 0);
            run("random", 1);
        end

        // Reset abort mid-window with a stretch pending.
        svmod = 1'b0; softbrk = 1'b0; cpuwr = 1'b1; iawres = '0;
        iawmsk = '0; causeclr = 1'b0;
        run("abort_idle", 1);
        svmod = 1'b1;    run("abort_win", 1);
        iawres = 2'b11;  run("abort_req", 1);
        iawres = 2'b00;  run("abort_pend", 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("abort/dut%0d/MASKACT", g),   32'(o_maskact[g]),  32'd1);
            check($sformatf("abort/dut%0d/CPUWRIAW", g),  32'(o_cpuwriaw[g]), 32'd0);
            check($sformatf("abort/dut%0d/SVSTOPIAW", g), 32'(o_svstop[g]),   32'd0);
            check($sformatf("abort/dut%0d/PERISVIB", g),  32'(o_perisvib[g]), 32'd1);
            check($sformatf("abort/dut%0d/IAWCAUSE", g),  32'(o_cause[g]),    32'd0);
        end
        model_reset();
        run("in_reset", 1);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_step();
        run("after_reset", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
